bcd_to_bin_seq: RTL and testbench
=================================

# bcd_to_bin_seq

Sequential, parametrised multi-digit BCD-to-binary converter. Generalises the single-digit decimal-to-binary decode to `DIGITS` packed BCD digits. Uses one multiply-by-ten-and-add step per clock, from the most significant digit down. Sits between decimal entry sources (keypads, DIP-switch digit banks, serial decimal parsers) and binary datapaths, with valid/ready handshakes on both sides and optional invalid-digit detection.

## Interface
Parameters:
- `DIGITS`, default 4: number of packed BCD digits; legal 1..8.
- `OUT_W`, default 14: binary result width. Must be ≥ ceil(log2(10^DIGITS)) for exact results; smaller values give results modulo 2^OUT_W.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `bcd_in`  in  4*DIGITS: packed BCD; digit k at bits [4k+3:4k]; digit DIGITS-1 is most significant.
- `in_valid`  in  1: `bcd_in` is valid.
- `in_ready`  out  1: converter can accept an input.
- `bin_out`  out  OUT_W: binary result, held stable while `out_valid` is 1.
- `err`  out  1: at least one digit of the converted word was > 9; qualified by `out_valid`.
- `out_valid`  out  1: result is available.
- `out_ready`  in  1: consumer accepts the result.

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `bcd_in` into the shift register, clear `acc` and the sticky error, load digit counter = DIGITS-1, go to CONV.
- CONV:
  - Each cycle: `acc` ← (acc<<3)+(acc<<1)+digit, where digit is the top nibble of the shift register. All arithmetic is truncated to OUT_W bits.
  - Shift the register left by 4 and decrement the counter.
  - If digit > 9, set the sticky error.
  - After the step with counter = 0, go to DONE.
- DONE:
  - `out_valid`=1, `bin_out`=acc, `err`=sticky error.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in CONV and DONE. Inputs presented then are ignored, not queued.
- `out_valid` never drops without `out_ready`. `bin_out` and `err` do not change while `out_valid`=1.
- Reset in any state: state→IDLE; `bin_out`=0, `err`=0, `out_valid`=0, `in_ready`=1 in the cycle after the reset edge. Any in-flight conversion is discarded and produces no output.
- Reset values: `bin_out`=0, `err`=0, `out_valid`=0, `in_ready`=1.

## Timing
- Accept edge T0 (IDLE, `in_valid`=1). CONV covers edges T1..T_DIGITS. `out_valid`=1 from edge T_DIGITS onward.
- Latency: `out_valid` rises DIGITS cycles after the accept edge.
- If `out_ready`=1 when `out_valid` first rises, DONE lasts exactly one cycle. `in_ready` returns 1 the next cycle.
- Minimum input-to-input spacing: DIGITS+2 cycles.
- `out_ready` has no effect outside DONE. `in_valid` has no effect outside IDLE.
- `out_ready` asserted continuously before `out_valid` is legal. The result is still presented for at least one cycle.

## Configuration
- Macro `BCD2BIN_ERR_EN`.
- Defined:
  - Digit > 9 sets `err`=1 for that result.
  - `bin_out` is forced to 0 in DONE when `err`=1.
- Undefined:
  - No digit check; `err` is tied to 0.
  - Invalid nibbles enter the arithmetic at their raw 4-bit value (e.g. 0xA weighs 10). Behaviour is deterministic; no X is ever driven.

## Test plan
- DIGITS=4, OUT_W=14, `out_ready`=1; `bcd_in`=0x1234 → `out_valid` 4 cycles after accept, `bin_out`=0x04D2, `err`=0; `in_ready`=1 one cycle later.
- `bcd_in`=0x9999 then 0x0000 back-to-back, at the earliest `in_ready` → `bin_out`=0x270F, then `bin_out`=0x0000. Accept edges are 6 cycles apart.
- Backpressure: `bcd_in`=0x0042, `out_ready`=0 for 10 cycles → `out_valid` held, `bin_out`=0x002A stable, `in_ready`=0 throughout. A second `in_valid` pulse during this window is ignored.
- `bcd_in`=0x12A4:
  - With `BCD2BIN_ERR_EN`: `err`=1, `bin_out`=0.
  - Without: `err`=0, `bin_out`=1*1000+2*100+10*10+4=1304=0x0518.
- Reset mid-CONV: accept 0x5678, drive `rst_n`=0 at edge T2 → next cycle `out_valid`=0, `bin_out`=0, `in_ready`=1; no result is ever emitted for 0x5678.
- DIGITS=2, OUT_W=4 (undersized): `bcd_in`=0x99 → `bin_out`=99 mod 16=3, 2-cycle latency.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential multi-digit packed BCD to binary converter
//
// Converts DIGITS packed BCD digits to binary, one multiply-by-ten-and-add
// step per clock, starting from the most significant digit.
//
// Optional feature macro: BCD2BIN_ERR_EN
//   defined   : a digit > 9 sets err for that result and forces bin_out to 0
//   undefined : no digit check, err tied to 0, invalid nibbles weigh their raw value
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   bcd_in     in   packed BCD, digit k at [4k+3:4k], digit DIGITS-1 most significant
//   in_valid   in   bcd_in is valid
//   in_ready   out  converter can accept an input (IDLE only)
//   bin_out    out  binary result, stable while out_valid is 1, 0 otherwise
//   err        out  invalid digit seen in the converted word, qualified by out_valid
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      bin_out,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          r_state;
  logic [4*DIGITS-1:0] r_shift;
  logic [OUT_W-1:0]    r_acc;
  // DIGITS is at most 8, so the remaining-digit count always fits in 3 bits.
  logic [2:0]          r_cnt;

  logic [3:0]          w_digit;
  logic [OUT_W-1:0]    w_acc_next;

  assign w_digit = r_shift[4*DIGITS-1 -: 4];

  // acc*10 + digit, built from shifts; wraps naturally at OUT_W bits.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + OUT_W'(w_digit);

`ifdef BCD2BIN_ERR_EN
  logic r_err;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= 3'd0;
`ifdef BCD2BIN_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= bcd_in;
            r_acc   <= '0;
            r_cnt   <= 3'(DIGITS - 1);
`ifdef BCD2BIN_ERR_EN
            r_err   <= 1'b0;
`endif
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc   <= w_acc_next;
          r_shift <= r_shift << 4;
          r_cnt   <= r_cnt - 3'd1;
`ifdef BCD2BIN_ERR_EN
          if (w_digit > 4'd9) begin
            r_err <= 1'b1;
          end
`endif
          if (r_cnt == 3'd0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  // Outputs are gated by DONE so they read 0 right after reset and between results.
`ifdef BCD2BIN_ERR_EN
  assign err     = out_valid & r_err;
  assign bin_out = (out_valid && !r_err) ? r_acc : '0;
`else
  assign err     = 1'b0;
  assign bin_out = out_valid ? r_acc : '0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - directed self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] bin_out;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  bcd2_in;
  logic        in2_valid;
  logic        in2_ready;
  logic [3:0]  bin2_out;
  logic        err2;
  logic        out2_valid;
  logic        out2_ready;

  int n_chk = 0;
  int n_err = 0;

  bcd_to_bin_seq #(.DIGITS(4), .OUT_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .in_valid(in_valid),
    .in_ready(in_ready), .bin_out(bin_out), .err(err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  bcd_to_bin_seq #(.DIGITS(2), .OUT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd2_in), .in_valid(in2_valid),
    .in_ready(in2_ready), .bin_out(bin2_out), .err(err2),
    .out_valid(out2_valid), .out_ready(out2_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one word at the next negedge, wait for out_valid (bounded).
  // Returns #1 after the edge where out_valid first rose.
  task automatic convert(input logic [15:0] bcd, output int lat,
                         output logic [13:0] bin, output logic e, output longint acc_t);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    bcd_in   = bcd;
    in_valid = 1'b1;
    @(posedge clk);
    acc_t = $time;
    #1;
    in_valid = 1'b0;
    bcd_in   = 16'h0;
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("out_valid_seen", 32'(lat != 0), 32'd1);
    bin = bin_out;
    e   = err;
  endtask

  // With out_ready high, DONE lasts one cycle and IDLE returns.
  task automatic check_release(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [13:0] bin;
    logic        e;
    longint      t_a;
    longint      t_b;
    int          lat2;

    rst_n      = 1'b0;
    bcd_in     = 16'h0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    bcd2_in    = 8'h0;
    in2_valid  = 1'b0;
    out2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin_out", 32'(bin_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Basic conversion with out_ready held high beforehand.
    convert(16'h1234, lat, bin, e, t_a);
    chk("t1234_latency", 32'(lat), 32'd4);
    chk("t1234_bin", 32'(bin), 32'h04D2);
    chk("t1234_err", 32'(e), 32'd0);
    check_release("t1234");

    // Back-to-back at the earliest in_ready.
    convert(16'h9999, lat, bin, e, t_a);
    chk("t9999_bin", 32'(bin), 32'h270F);
    chk("t9999_err", 32'(e), 32'd0);
    check_release("t9999");
    convert(16'h0000, lat, bin, e, t_b);
    chk("t0000_bin", 32'(bin), 32'h0000);
    chk("t0000_latency", 32'(lat), 32'd4);
    chk("b2b_spacing_cycles", 32'((t_b - t_a) / 10), 32'd6);
    check_release("t0000");

    // Backpressure: result held, in_ready low, extra input ignored.
    out_ready = 1'b0;
    convert(16'h0042, lat, bin, e, t_a);
    chk("t0042_bin", 32'(bin), 32'h002A);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bcd_in   = 16'h0011;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_bin_stable", 32'(bin_out), 32'h002A);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    bcd_in    = 16'h0;
    out_ready = 1'b1;
    check_release("bp");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ignored_no_output", 32'(out_valid), 32'd0);
    end

    // Invalid digit.
    convert(16'h12A4, lat, bin, e, t_a);
`ifdef BCD2BIN_ERR_EN
    chk("t12A4_err", 32'(e), 32'd1);
    chk("t12A4_bin", 32'(bin), 32'h0000);
`else
    chk("t12A4_err", 32'(e), 32'd0);
    chk("t12A4_bin", 32'(bin), 32'h0518);
`endif
    check_release("t12A4");

    // Reset during CONV: rst_n sampled low at edge T2.
    @(negedge clk);
    bcd_in   = 16'h5678;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_bin_out", 32'(bin_out), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_output", 32'(out_valid), 32'd0);
    end

    // Undersized instance: 99 mod 16 = 3, two-cycle latency.
    @(negedge clk);
    chk("d2_in_ready", 32'(in2_ready), 32'd1);
    bcd2_in   = 8'h99;
    in2_valid = 1'b1;
    @(posedge clk);
    #1;
    in2_valid = 1'b0;
    lat2 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out2_valid) begin
        lat2 = i;
        break;
      end
    end
    chk("d2_latency", 32'(lat2), 32'd2);
    chk("d2_bin", 32'(bin2_out), 32'd3);
    chk("d2_err", 32'(err2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
